// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encoding,
// FSM state encoding, default datapath width and the divide-by-zero quotient.
package hilo_muldiv_seq_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Quotient reported for a zero divisor; HI keeps the dividend.
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// Decode-stage <-> mul/div sequencer bundle. The master (decode) presents
// operations and MF requests; the slave (sequencer) returns stall and the
// HI/LO write strobes with their data.
interface hilo_muldiv_seq_if
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            mf_req;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] hi_out;
  logic [XLEN-1:0] lo_out;

  modport master (
    output start, op, a, b, mf_req, flush,
    input  busy, stall, hi_we, lo_we, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b, mf_req, flush,
    output busy, stall, hi_we, lo_we, hi_out, lo_out
  );
endinterface

// File: rtl/hilo_muldiv_seq_step.sv
// One iteration of the unsigned datapath on the {acc, q} pair.
//   multiply: conditional add of m into acc, then shift {carry, acc, q} right
//   divide:   shift {acc, q} left, trial-subtract m, keep result if no borrow
// Operands are magnitudes; signs are handled by the sequencer.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] q_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Single combinational iteration; diff's top bit is the borrow, since the
  // partial remainder always stays below 2*m.
  always_comb begin
    sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
    shifted = {acc_i, q_i[XLEN-1]};
    diff    = shifted - {1'b0, m_i};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        acc_o = diff[XLEN-1:0];
        q_o   = {q_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = shifted[XLEN-1:0];
        q_o   = {q_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[XLEN:1];
      q_o   = {sum[0], q_i[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO multiply/divide sequencer. Accepts MULT/MULTU/DIV/DIVU from decode,
// retires one bit per cycle through muldiv_step, applies the sign fix and
// issues a one-cycle HI/LO write strobe. Stalls decode on MFHI/MFLO or a new
// mul/div while busy.
// Optional: MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier
// bits are zero and a divide-by-zero after a single cycle.
//
//   state  | meaning
//   S_IDLE | waiting for start; operands latched as magnitudes on accept
//   S_RUN  | one iteration per cycle, count_q = iterations already done
//   S_DONE | result registered, HI/LO strobes high for this cycle only
module hilo_muldiv_seq
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  hilo_muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(ITER);

  state_e          state_q;
  logic [CW-1:0]   count_q;
  logic            is_div_q;
  logic            div0_q;
  logic            neg_q;
  logic            rem_neg_q;
  logic            busy_q;
  logic            hi_we_q;
  logic            lo_we_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] m_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] hi_out_q;
  logic [XLEN-1:0] lo_out_q;

  logic              sa_d;
  logic              sb_d;
  logic [XLEN-1:0]   a_mag_d;
  logic [XLEN-1:0]   b_mag_d;
  logic [XLEN-1:0]   acc_d;
  logic [XLEN-1:0]   q_d;
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   quo_d;
  logic [XLEN-1:0]   rem_d;
  logic [XLEN-1:0]   res_hi_d;
  logic [XLEN-1:0]   res_lo_d;
  logic              early_d;
  logic              last_d;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .m_i      (m_q),
    .acc_o    (acc_d),
    .q_o      (q_d)
  );

  // Operand magnitudes and sign flags for the op being presented.
  always_comb begin
    sa_d    = is_signed_op(bus.op) & bus.a[XLEN-1];
    sb_d    = is_signed_op(bus.op) & bus.b[XLEN-1];
    a_mag_d = sa_d ? -bus.a : bus.a;
    b_mag_d = sb_d ? -bus.b : bus.b;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [CW:0]     rem_cnt_d;
  logic [XLEN-1:0] rem_mask_d;

  // Bits of the multiplier still unconsumed after this iteration.
  always_comb begin
    rem_cnt_d  = (CW+1)'(ITER-1) - {1'b0, count_q};
    rem_mask_d = ({{(XLEN-1){1'b0}}, 1'b1} << rem_cnt_d) - XLEN'(1);
    early_d    = is_div_q ? div0_q : ((q_d & rem_mask_d) == '0);
  end
`else
  assign early_d = 1'b0;
`endif

  assign last_d = (count_q == CW'(ITER-1)) | early_d;

  // Final HI/LO from the post-iteration {acc, q}, with sign fix and div-by-zero.
  always_comb begin
    prod_d = {acc_d, q_d};
`ifdef MULDIV_EARLY_OUT_EN
    prod_d = prod_d >> rem_cnt_d;
`endif
    if (neg_q) prod_d = -prod_d;
    quo_d = neg_q ? -q_d : q_d;
    rem_d = rem_neg_q ? -acc_d : acc_d;
    if (is_div_q) begin
      res_hi_d = div0_q ? a_q : rem_d;
      res_lo_d = div0_q ? XLEN'(DIV0_QUOTIENT) : quo_d;
    end else begin
      res_hi_d = prod_d[2*XLEN-1:XLEN];
      res_lo_d = prod_d[XLEN-1:0];
    end
  end

  // Sequencer FSM with registered busy, strobes and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_we_q   <= 1'b0;
      lo_we_q   <= 1'b0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      a_q       <= '0;
      hi_out_q  <= '0;
      lo_out_q  <= '0;
    end else begin
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            count_q   <= '0;
            is_div_q  <= bus.op[1];
            div0_q    <= bus.op[1] & (bus.b == '0);
            neg_q     <= sa_d ^ sb_d;
            rem_neg_q <= sa_d;
            a_q       <= bus.a;
            acc_q     <= '0;
            // Divide iterates on the dividend with the divisor as m;
            // multiply iterates on the multiplier with the multiplicand as m.
            q_q       <= bus.op[1] ? a_mag_d : b_mag_d;
            m_q       <= bus.op[1] ? b_mag_d : a_mag_d;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q   <= acc_d;
            q_q     <= q_d;
            count_q <= count_q + CW'(1);
            if (last_d) begin
              state_q  <= S_DONE;
              hi_out_q <= res_hi_d;
              lo_out_q <= res_lo_d;
              hi_we_q  <= 1'b1;
              lo_we_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in DONE must still kill the strobes of that same cycle.
  assign bus.busy   = busy_q;
  assign bus.stall  = busy_q & (bus.mf_req | bus.start);
  assign bus.hi_we  = hi_we_q & ~bus.flush;
  assign bus.lo_we  = lo_we_q & ~bus.flush;
  assign bus.hi_out = hi_out_q;
  assign bus.lo_out = lo_out_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Self-checking bench for hilo_muldiv_seq (default build): vector table plus
// random ops through a scoreboard, and hand sequences for stall, flush, held
// start and mid-operation reset.
module tb_hilo_muldiv_seq;
  import hilo_muldiv_seq_pkg::*;

  localparam int ITER = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_seq_if #(.XLEN(32)) bus();

  hilo_muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[13];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT:  begin sp = sa * sb; {hi, lo} = sp; end
      OP_MULTU: begin up = ua * ub; {hi, lo} = up; end
      OP_DIV: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      end
    endcase
  endfunction

  // Scoreboard: every strobe must match the oldest expected result and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.hi_we === 1'b1 || bus.lo_we === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("hi_out", {32'd0, bus.hi_out}, {32'd0, e.hi});
        chk("lo_out", {32'd0, bus.lo_out}, {32'd0, e.lo});
        chk("we_pair", {62'd0, bus.hi_we, bus.lo_we}, 64'd3);
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Present one op in the current cycle and expect its strobe ITER+1 later.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.hi = hi;
    e.lo = lo;
    e.due = cyc + ITER + 1;
    exp_q.push_back(e);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    int          bad;
    logic [1:0]  rop;
    logic [31:0] ra, rb, rhi, rlo;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[4]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[7]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[8]  = '{OP_MULTU, 32'h1234_5678, 32'd0,         32'd0,         32'd0};
    vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[11] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
    vecs[12] = '{OP_MULT,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};

    bus.start  = 1'b0;
    bus.op     = OP_MULT;
    bus.a      = '0;
    bus.b      = '0;
    bus.mf_req = 1'b1;
    bus.flush  = 1'b0;
    rst        = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_busy",  {63'd0, bus.busy},  64'd0);
    chk("reset_stall", {63'd0, bus.stall}, 64'd0);
    chk("reset_we",    {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
    chk("reset_data",  {bus.hi_out, bus.lo_out}, 64'd0);
    tick();
    rst        = 1'b0;
    bus.mf_req = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      drain();
    end

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      model(rop, ra, rb, rhi, rlo);
      issue(rop, ra, rb, rhi, rlo);
      drain();
    end

    // MFHI held from cycle 1: stall through DONE, released the cycle after.
    issue(OP_MULTU, 32'h10, 32'h20, 32'd0, 32'h200);
    bus.mf_req = 1'b1;
    bad = 0;
    for (int c = 1; c <= ITER + 1; c++) begin
      @(negedge clk);
      if (bus.stall !== 1'b1) bad++;
      tick();
    end
    @(negedge clk);
    chk("stall_cycles_1_33", 64'(bad), 64'd0);
    chk("stall_released", {63'd0, bus.stall}, 64'd0);
    chk("busy_after_done", {63'd0, bus.busy}, 64'd0);
    chk("strobe_one_cycle", {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
    bus.mf_req = 1'b0;
    drain();

    // start held while busy: second op accepted in the first IDLE cycle.
    c0 = cyc;
    bus.start = 1'b1;
    bus.op = OP_MULT; bus.a = 32'hFFFF_FFFD; bus.b = 32'd5;
    exp_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF1, c0 + ITER + 1});
    tick();
    bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    exp_q.push_back('{32'd2, 32'd14, c0 + 2 * (ITER + 1) + 1});
    while (cyc < c0 + ITER + 1) tick();
    @(negedge clk);
    chk("held_start_stall", {63'd0, bus.stall}, 64'd1);
    tick();
    @(negedge clk);
    chk("held_start_idle_stall", {63'd0, bus.stall}, 64'd0);
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    chk("held_start_accepted", {63'd0, bus.busy}, 64'd1);
    drain();

    // flush at cycle 10 of a DIV: idle next cycle, never strobes.
    c0 = cyc;
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
    tick();
    bus.start = 1'b0;
    while (cyc < c0 + 10) tick();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("busy_before_flush", {63'd0, bus.busy}, 64'd1);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("busy_after_flush", {63'd0, bus.busy}, 64'd0);
    repeat (40) tick();
    issue(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    drain();

    // flush together with start in IDLE: start ignored.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd3;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_start_ignored", {63'd0, bus.busy}, 64'd0);
    repeat (40) tick();

    // flush during DONE suppresses that cycle's strobes.
    c0 = cyc;
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    while (cyc < c0 + ITER + 1) tick();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("done_flush_busy", {63'd0, bus.busy}, 64'd1);
    chk("done_flush_we", {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("done_flush_idle", {63'd0, bus.busy}, 64'd0);
    tick();

    // Prime nonzero HI/LO, then reset at cycle 5 of the next op.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    drain();
    c0 = cyc;
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9;
    tick();
    bus.start = 1'b0;
    while (cyc < c0 + 5) tick();
    rst = 1'b1;
    bus.mf_req = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy",  {63'd0, bus.busy},  64'd0);
    chk("rst_mid_stall", {63'd0, bus.stall}, 64'd0);
    chk("rst_mid_we",    {62'd0, bus.hi_we, bus.lo_we}, 64'd0);
    chk("rst_mid_data",  {bus.hi_out, bus.lo_out}, 64'd0);
    bus.mf_req = 1'b0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
